// File: rtl/rob_param.sv
// rtl/rob_param.sv - parametrised reorder buffer with multi-port CDB write-back, store handshake and flush
//
// Purpose: tracks in-flight instructions in program order, accepts out-of-order
// results from CDB_PORTS write-back ports and retires at most one entry per cycle.
// Optional feature: define ROB_CDB_BYPASS_EN to let the operand check ports see
// same-cycle CDB results; undefined (default) they read stored state only.
//
// Ports:
//   clk, rst (async, active-low)
//   alloc_*            decoder allocation request, alloc_ready/alloc_tag/count status
//   cdb_*              per-port write-back (flattened vectors, port 0 in the low bits)
//   chk_tag*/chk_*     combinational operand lookup
//   reg_*              registered RegFile commit pulse and fields
//   dcache_*           registered store pulse and fields, dcache_ready back-pressure
//   pc_modify/npc      registered redirect pulse on mispredict
//   brp_*              registered branch-predictor update pulse
module rob_param #(
  parameter int DEPTH     = 8,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int REG_W     = 5,
  parameter int BRA_W     = 8,
  parameter int CDB_PORTS = 2,
  localparam int PTR_W    = $clog2(DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          alloc_valid,
  output logic                          alloc_ready,
  input  logic [2:0]                    alloc_op,
  input  logic [REG_W-1:0]              alloc_reg,
  input  logic [BRA_W-1:0]              alloc_bra_addr,
  output logic [PTR_W-1:0]              alloc_tag,
  output logic [PTR_W:0]                count,
  input  logic [CDB_PORTS-1:0]          cdb_valid,
  input  logic [CDB_PORTS*PTR_W-1:0]    cdb_tag,
  input  logic [CDB_PORTS*DATA_W-1:0]   cdb_value,
  input  logic [CDB_PORTS*ADDR_W-1:0]   cdb_addr,
  input  logic [CDB_PORTS-1:0]          cdb_mispredict,
  input  logic [CDB_PORTS-1:0]          cdb_taken,
  input  logic [PTR_W-1:0]              chk_tag1,
  input  logic [PTR_W-1:0]              chk_tag2,
  output logic [DATA_W-1:0]             chk_value1,
  output logic [DATA_W-1:0]             chk_value2,
  output logic                          chk_ready1,
  output logic                          chk_ready2,
  output logic                          reg_modify,
  output logic [REG_W-1:0]              reg_name,
  output logic [DATA_W-1:0]             reg_data,
  output logic [PTR_W-1:0]              reg_entry,
  output logic                          dcache_write,
  output logic [3:0]                    dcache_mask,
  output logic [ADDR_W-1:0]             dcache_addr,
  output logic [DATA_W-1:0]             dcache_data,
  input  logic                          dcache_ready,
  output logic                          pc_modify,
  output logic [ADDR_W-1:0]             npc,
  output logic                          brp_update,
  output logic [BRA_W-1:0]              brp_addr,
  output logic                          brp_result
);

  localparam logic [2:0] OP_BR = 3'd1, OP_NORM = 3'd2, OP_SB = 3'd3, OP_SH = 3'd4, OP_SW = 3'd5;

  logic              busy_q [DEPTH];
  logic              rdy_q  [DEPTH];
  logic [2:0]        op_q   [DEPTH];
  logic [REG_W-1:0]  reg_q  [DEPTH];
  logic [DATA_W-1:0] val_q  [DEPTH];
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [BRA_W-1:0]  bra_q  [DEPTH];
  logic              mis_q  [DEPTH];
  logic              tk_q   [DEPTH];
  logic [PTR_W-1:0]  head, tail;

  assign alloc_ready = (count != (PTR_W+1)'(DEPTH));
  assign alloc_tag   = tail;

  // Per-entry CDB select; scanning ports high-to-low lets the lowest port win.
  logic              wr_hit  [DEPTH];
  logic [DATA_W-1:0] wr_val  [DEPTH];
  logic [ADDR_W-1:0] wr_addr [DEPTH];
  logic              wr_mis  [DEPTH];
  logic              wr_tk   [DEPTH];

  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      wr_hit[e]  = 1'b0;
      wr_val[e]  = '0;
      wr_addr[e] = '0;
      wr_mis[e]  = 1'b0;
      wr_tk[e]   = 1'b0;
      for (int p = CDB_PORTS - 1; p >= 0; p--) begin
        if (cdb_valid[p] && (cdb_tag[p*PTR_W +: PTR_W] == PTR_W'(e))) begin
          wr_hit[e]  = 1'b1;
          wr_val[e]  = cdb_value[p*DATA_W +: DATA_W];
          wr_addr[e] = cdb_addr[p*ADDR_W +: ADDR_W];
          wr_mis[e]  = cdb_mispredict[p];
          wr_tk[e]   = cdb_taken[p];
        end
      end
    end
  end

  // Head decode
  logic [2:0]        h_op;
  logic [DATA_W-1:0] h_val;
  logic [1:0]        h_lo;
  logic              h_store, do_commit, do_flush, do_alloc;
  logic              st_write;
  logic [3:0]        st_mask;
  logic [DATA_W-1:0] st_data;

  assign h_op      = op_q[head];
  assign h_val     = val_q[head];
  assign h_lo      = addr_q[head][1:0];
  assign h_store   = (h_op == OP_SB) || (h_op == OP_SH) || (h_op == OP_SW);
  assign do_commit = busy_q[head] && rdy_q[head] && (!h_store || dcache_ready);
  assign do_flush  = do_commit && (h_op == OP_BR) && mis_q[head];
  assign do_alloc  = alloc_valid && alloc_ready && !do_flush;

  // Store lane formatting; misaligned SH/SW retire silently.
  always_comb begin
    st_write = 1'b0;
    st_mask  = 4'b0000;
    st_data  = h_val;
    case (h_op)
      OP_SB: begin
        st_write = 1'b1;
        st_mask  = 4'b0001 << h_lo;
        st_data  = h_val << {h_lo, 3'b000};
      end
      OP_SH: begin
        st_write = !h_lo[0];
        st_mask  = h_lo[1] ? 4'b1100 : 4'b0011;
        st_data  = h_lo[1] ? (h_val << 16) : h_val;
      end
      OP_SW: begin
        st_write = (h_lo == 2'b00);
        st_mask  = 4'b1111;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      for (int e = 0; e < DEPTH; e++) begin
        busy_q[e] <= 1'b0;
        rdy_q[e]  <= 1'b0;
        op_q[e]   <= '0;
        reg_q[e]  <= '0;
        val_q[e]  <= '0;
        addr_q[e] <= '0;
        bra_q[e]  <= '0;
        mis_q[e]  <= 1'b0;
        tk_q[e]   <= 1'b0;
      end
      reg_modify   <= 1'b0;
      reg_name     <= '0;
      reg_data     <= '0;
      reg_entry    <= '0;
      dcache_write <= 1'b0;
      dcache_mask  <= '0;
      dcache_addr  <= '0;
      dcache_data  <= '0;
      pc_modify    <= 1'b0;
      npc          <= '0;
      brp_update   <= 1'b0;
      brp_addr     <= '0;
      brp_result   <= 1'b0;
    end else begin
      reg_modify   <= 1'b0;
      dcache_write <= 1'b0;
      pc_modify    <= 1'b0;
      brp_update   <= 1'b0;

      for (int e = 0; e < DEPTH; e++) begin
        if (wr_hit[e] && busy_q[e] && !rdy_q[e]) begin
          rdy_q[e]  <= 1'b1;
          val_q[e]  <= wr_val[e];
          addr_q[e] <= wr_addr[e];
          mis_q[e]  <= wr_mis[e];
          tk_q[e]   <= wr_tk[e];
        end
      end

      if (do_commit) begin
        busy_q[head] <= 1'b0;
        rdy_q[head]  <= 1'b0;
        head         <= head + 1'b1;
        if (h_op == OP_NORM) begin
          reg_modify <= 1'b1;
          reg_name   <= reg_q[head];
          reg_data   <= h_val;
          reg_entry  <= head;
        end
        if (h_op == OP_BR) begin
          brp_update <= 1'b1;
          brp_addr   <= bra_q[head];
          brp_result <= tk_q[head];
          if (mis_q[head]) begin
            pc_modify <= 1'b1;
            npc       <= addr_q[head];
          end
        end
        if (h_store && st_write) begin
          dcache_write <= 1'b1;
          dcache_mask  <= st_mask;
          dcache_addr  <= {addr_q[head][ADDR_W-1:2], 2'b00};
          dcache_data  <= st_data;
        end
      end

      // Placed after the commit clear so a new allocation into the retiring slot wins.
      if (do_alloc) begin
        busy_q[tail] <= 1'b1;
        rdy_q[tail]  <= 1'b0;
        op_q[tail]   <= alloc_op;
        reg_q[tail]  <= alloc_reg;
        bra_q[tail]  <= alloc_bra_addr;
        val_q[tail]  <= '0;
        tail         <= tail + 1'b1;
      end

      count <= count + (PTR_W+1)'(do_alloc) - (PTR_W+1)'(do_commit);

      if (do_flush) begin
        for (int e = 0; e < DEPTH; e++) begin
          busy_q[e] <= 1'b0;
          rdy_q[e]  <= 1'b0;
        end
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end
    end
  end

  // Operand lookup
  logic [PTR_W-1:0]  ct   [2];
  logic [DATA_W-1:0] cval [2];
  logic              crdy [2];

  assign ct[0] = chk_tag1;
  assign ct[1] = chk_tag2;

  always_comb begin
    for (int c = 0; c < 2; c++) begin
      crdy[c] = busy_q[ct[c]] && rdy_q[ct[c]];
      cval[c] = busy_q[ct[c]] ? val_q[ct[c]] : '0;
`ifdef ROB_CDB_BYPASS_EN
      for (int p = CDB_PORTS - 1; p >= 0; p--) begin
        if (cdb_valid[p] && busy_q[ct[c]] && (cdb_tag[p*PTR_W +: PTR_W] == ct[c])) begin
          crdy[c] = 1'b1;
          cval[c] = cdb_value[p*DATA_W +: DATA_W];
        end
      end
`else
      // Stored state only: a CDB result shows here one cycle after write-back.
`endif
    end
  end

  assign chk_value1 = cval[0];
  assign chk_value2 = cval[1];
  assign chk_ready1 = crdy[0];
  assign chk_ready2 = crdy[1];

endmodule

// File: tb/tb_rob_param.sv
// tb/tb_rob_param.sv - scoreboard bench for rob_param with queue-based reference model
module tb_rob_param;
  localparam int DEPTH = 8;
  localparam int PTR_W = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        alloc_valid, alloc_ready;
  logic [2:0]  alloc_op;
  logic [4:0]  alloc_reg;
  logic [7:0]  alloc_bra_addr;
  logic [2:0]  alloc_tag;
  logic [3:0]  count;
  logic [1:0]  cdb_valid, cdb_mispredict, cdb_taken;
  logic [5:0]  cdb_tag;
  logic [63:0] cdb_value, cdb_addr;
  logic [2:0]  chk_tag1, chk_tag2;
  logic [31:0] chk_value1, chk_value2;
  logic        chk_ready1, chk_ready2;
  logic        reg_modify;
  logic [4:0]  reg_name;
  logic [31:0] reg_data;
  logic [2:0]  reg_entry;
  logic        dcache_write;
  logic [3:0]  dcache_mask;
  logic [31:0] dcache_addr, dcache_data;
  logic        dcache_ready;
  logic        pc_modify;
  logic [31:0] npc;
  logic        brp_update;
  logic [7:0]  brp_addr;
  logic        brp_result;

  always #5 clk = ~clk;

  rob_param dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_op(alloc_op),
    .alloc_reg(alloc_reg), .alloc_bra_addr(alloc_bra_addr), .alloc_tag(alloc_tag), .count(count),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value), .cdb_addr(cdb_addr),
    .cdb_mispredict(cdb_mispredict), .cdb_taken(cdb_taken),
    .chk_tag1(chk_tag1), .chk_tag2(chk_tag2), .chk_value1(chk_value1), .chk_value2(chk_value2),
    .chk_ready1(chk_ready1), .chk_ready2(chk_ready2),
    .reg_modify(reg_modify), .reg_name(reg_name), .reg_data(reg_data), .reg_entry(reg_entry),
    .dcache_write(dcache_write), .dcache_mask(dcache_mask), .dcache_addr(dcache_addr),
    .dcache_data(dcache_data), .dcache_ready(dcache_ready),
    .pc_modify(pc_modify), .npc(npc),
    .brp_update(brp_update), .brp_addr(brp_addr), .brp_result(brp_result)
  );

  typedef struct {
    int          tag;
    int          op;
    int          rg;
    int          bra;
    bit          rdy;
    logic [31:0] val;
    logic [31:0] addr;
    bit          mis;
    bit          tk;
  } ent_t;

  // kind 0: reg (f0 name, f1 data, f2 entry); 1: store (f0 mask, f1 addr, f2 data);
  // kind 2: branch (f0 bra, f1 taken, f2 npc, pcm redirect)
  typedef struct {
    int          kind;
    logic [31:0] f0;
    logic [31:0] f1;
    logic [31:0] f2;
    bit          pcm;
  } ev_t;

  ent_t q[$];
  ev_t  exp_q[$];
  int   tail_m = 0;
  int   checks = 0;
  int   failures = 0;
  bit   mon_en = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic int find(int tag);
    for (int i = 0; i < q.size(); i++) if (q[i].tag == tag) return i;
    return -1;
  endfunction

  task automatic clear_inputs();
    alloc_valid = 0; alloc_op = 3'd2; alloc_reg = 0; alloc_bra_addr = 0;
    cdb_valid = 0; cdb_tag = 0; cdb_value = 0; cdb_addr = 0; cdb_mispredict = 0; cdb_taken = 0;
    chk_tag1 = 3'($urandom_range(0, 7));
    chk_tag2 = 3'($urandom_range(0, 7));
  endtask

  task automatic set_alloc(int op, int rg, int bra);
    alloc_valid = 1; alloc_op = 3'(op); alloc_reg = 5'(rg); alloc_bra_addr = 8'(bra);
  endtask

  task automatic set_cdb(int p, int tag, logic [31:0] v, logic [31:0] a, bit m, bit t);
    cdb_valid[p] = 1'b1;
    cdb_tag[p*3 +: 3] = 3'(tag);
    cdb_value[p*32 +: 32] = v;
    cdb_addr[p*32 +: 32] = a;
    cdb_mispredict[p] = m;
    cdb_taken[p] = t;
  endtask

  // Called at posedge+1 with inputs set; checks lookups, advances the model, crosses one edge.
  task automatic step();
    int   n0;
    bit   fl;
    ent_t e;
    ev_t  ev;
    int   a;
    bit   ok;
    #1;
    for (int c = 0; c < 2; c++) begin
      int          t;
      int          i;
      bit          er;
      logic [31:0] exv;
      t = (c == 0) ? int'(chk_tag1) : int'(chk_tag2);
      i = find(t);
      er = 0; exv = 0;
      if (i >= 0) begin er = q[i].rdy; exv = q[i].val; end
`ifdef ROB_CDB_BYPASS_EN
      if (i >= 0)
        for (int p = 1; p >= 0; p--)
          if (cdb_valid[p] && int'(cdb_tag[p*3 +: 3]) == t) begin er = 1; exv = cdb_value[p*32 +: 32]; end
`endif
      chk(c == 0 ? "chk_ready1" : "chk_ready2", c == 0 ? chk_ready1 : chk_ready2, er);
      if (er || i < 0)
        chk(c == 0 ? "chk_value1" : "chk_value2", c == 0 ? chk_value1 : chk_value2, er ? exv : 32'h0);
    end

    n0 = q.size();
    fl = 0;
    if (n0 > 0 && q[0].rdy && (q[0].op < 3 || dcache_ready)) begin
      e = q.pop_front();
      ev.kind = 0; ev.f0 = 0; ev.f1 = 0; ev.f2 = 0; ev.pcm = 0;
      ok = 1;
      a = int'(e.addr[1:0]);
      case (e.op)
        1: begin ev.kind = 2; ev.f0 = e.bra; ev.f1 = e.tk; ev.f2 = e.addr; ev.pcm = e.mis; fl = e.mis; end
        2: begin ev.kind = 0; ev.f0 = e.rg; ev.f1 = e.val; ev.f2 = e.tag; end
        3: begin ev.kind = 1; ev.f0 = 32'(1) << a; ev.f2 = e.val << (8 * a); end
        4: begin ev.kind = 1; ok = (a % 2 == 0); ev.f0 = (a >= 2) ? 32'hC : 32'h3;
                 ev.f2 = (a >= 2) ? (e.val << 16) : e.val; end
        default: begin ev.kind = 1; ok = (a == 0); ev.f0 = 32'hF; ev.f2 = e.val; end
      endcase
      if (ev.kind == 1) ev.f1 = e.addr - 32'(a);
      if (ok) exp_q.push_back(ev);
    end

    for (int p = 0; p < 2; p++) begin
      if (cdb_valid[p] && !fl) begin
        int i;
        i = find(int'(cdb_tag[p*3 +: 3]));
        if (i >= 0 && !q[i].rdy) begin
          q[i].rdy = 1; q[i].val = cdb_value[p*32 +: 32]; q[i].addr = cdb_addr[p*32 +: 32];
          q[i].mis = cdb_mispredict[p]; q[i].tk = cdb_taken[p];
        end
      end
    end

    if (alloc_valid && n0 != DEPTH && !fl) begin
      ent_t ne;
      ne.tag = tail_m; ne.op = int'(alloc_op); ne.rg = int'(alloc_reg); ne.bra = int'(alloc_bra_addr);
      ne.rdy = 0; ne.val = 0; ne.addr = 0; ne.mis = 0; ne.tk = 0;
      q.push_back(ne);
      tail_m = (tail_m + 1) % DEPTH;
    end
    if (fl) begin q.delete(); tail_m = 0; end

    @(posedge clk); #1;
    chk("count", count, q.size());
    chk("alloc_tag", alloc_tag, tail_m);
    chk("alloc_ready", alloc_ready, q.size() != DEPTH);
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) begin clear_inputs(); dcache_ready = 1; step(); end
  endtask

  // Writes results for not-yet-ready entries until the buffer empties or the budget runs out.
  task automatic drain(int budget);
    for (int k = 0; k < budget && q.size() > 0; k++) begin
      int p;
      clear_inputs();
      dcache_ready = 1;
      p = 0;
      for (int i = 0; i < q.size() && p < 2; i++)
        if (!q[i].rdy) begin
          set_cdb(p, q[i].tag, $urandom, $urandom & 32'hFFFF_FFFC, 1'b0, 1'($urandom));
          p++;
        end
      step();
    end
    idle(2);
    chk("drain_count", count, 0);
  endtask

  always @(negedge clk) begin
    if (mon_en && (reg_modify || dcache_write || brp_update || pc_modify)) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_commit actual reg=%0b st=%0b brp=%0b pc=%0b required=none",
                 reg_modify, dcache_write, brp_update, pc_modify);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        chk("commit_kind", {reg_modify, dcache_write, brp_update, pc_modify},
            {e.kind == 0, e.kind == 1, e.kind == 2, e.pcm});
        case (e.kind)
          0: begin
            chk("reg_name", reg_name, e.f0);
            chk("reg_data", reg_data, e.f1);
            chk("reg_entry", reg_entry, e.f2);
          end
          1: begin
            chk("dcache_mask", dcache_mask, e.f0);
            chk("dcache_addr", dcache_addr, e.f1);
            chk("dcache_data", dcache_data, e.f2);
          end
          default: begin
            chk("brp_addr", brp_addr, e.f0);
            chk("brp_result", brp_result, e.f1);
            if (e.pcm) chk("npc", npc, e.f2);
          end
        endcase
      end
    end
  end

  initial begin
    int t0;
    clear_inputs();
    dcache_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", count, 0);
    chk("rst_alloc_ready", alloc_ready, 1);
    chk("rst_alloc_tag", alloc_tag, 0);
    chk("rst_pulses", {reg_modify, dcache_write, pc_modify, brp_update}, 0);
    @(negedge clk); rst = 1; mon_en = 1;
    @(posedge clk); #1;

    // Fill to DEPTH; ninth request must be ignored
    for (int i = 0; i < 9; i++) begin clear_inputs(); set_alloc(2, i + 1, 0); step(); end
    chk("full_tail", alloc_tag, 0);

    // Out-of-order completion 2,1,0 then in-order retirement
    clear_inputs(); set_cdb(0, 2, 32'h22, 0, 0, 0); step();
    clear_inputs(); set_cdb(0, 1, 32'h33, 0, 0, 0); step();
    clear_inputs(); set_cdb(0, 0, 32'h11, 0, 0, 0); step();
    drain(40);

    // Byte store stalled by dcache_ready
    clear_inputs(); t0 = tail_m; set_alloc(3, 0, 0); step();
    clear_inputs(); set_cdb(0, t0, 32'hAB, 32'h1003, 0, 0); step();
    for (int i = 0; i < 3; i++) begin clear_inputs(); dcache_ready = 0; step(); end
    chk("sb_stalled_count", count, 1);
    idle(3);

    // Mispredicted branch flushes two younger entries; a same-cycle CDB write is dropped
    clear_inputs(); t0 = tail_m; set_alloc(1, 0, 8'h5A); step();
    clear_inputs(); set_alloc(2, 7, 0); step();
    clear_inputs(); set_alloc(2, 8, 0); step();
    clear_inputs(); set_cdb(0, t0, 0, 32'h40, 1, 1); step();
    clear_inputs(); set_cdb(0, (t0 + 1) % DEPTH, 32'h77, 0, 0, 0); step();
    chk("flush_count", count, 0);
    idle(2);

    // Two ports hit tag 3 together; port 0 wins
    for (int i = 0; i < 4; i++) begin clear_inputs(); set_alloc(2, 20 + i, 0); step(); end
    clear_inputs(); chk_tag1 = 3; set_cdb(0, 3, 32'h5, 0, 0, 0); set_cdb(1, 3, 32'h9, 0, 0, 0); step();
    clear_inputs(); chk_tag1 = 3; step();
    drain(40);

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      clear_inputs();
      dcache_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) != 0) set_alloc($urandom_range(1, 5), $urandom_range(0, 31), $urandom_range(0, 255));
      for (int p = 0; p < 2; p++) begin
        if ($urandom_range(0, 1) == 1) begin
          int tg;
          if (q.size() > 0 && $urandom_range(0, 4) != 0) tg = q[$urandom_range(0, q.size() - 1)].tag;
          else tg = $urandom_range(0, 7);
          set_cdb(p, tg, $urandom, $urandom, ($urandom_range(0, 5) == 0), 1'($urandom));
        end
      end
      step();
    end
    drain(200);
    chk("scoreboard_empty", exp_q.size(), 0);

    // Asynchronous reset while a store pulse is up and five entries remain
    clear_inputs(); t0 = tail_m; set_alloc(5, 0, 0); step();
    for (int i = 0; i < 5; i++) begin clear_inputs(); set_alloc(2, i, 0); step(); end
    clear_inputs(); set_cdb(0, t0, 32'hDEAD_BEEF, 32'h2000, 0, 0); step();
    idle(1);
    chk("pre_rst_count", count, 5);
    chk("pre_rst_store_pulse", dcache_write, 1);
    mon_en = 0;
    #1 rst = 0;
    #1;
    chk("async_rst_count", count, 0);
    chk("async_rst_alloc_ready", alloc_ready, 1);
    chk("async_rst_alloc_tag", alloc_tag, 0);
    chk("async_rst_pulses", {reg_modify, dcache_write, pc_modify, brp_update}, 0);
    q.delete(); exp_q.delete(); tail_m = 0;
    @(negedge clk); rst = 1; mon_en = 1;
    @(posedge clk); #1;

    clear_inputs(); set_alloc(2, 9, 0); step();
    clear_inputs(); set_cdb(1, 0, 32'h1234, 0, 0, 0); step();
    idle(3);
    chk("final_scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rob_param.md
# rob_param

Parametrised reorder buffer for the out-of-order core. It sits between the decoder (allocation and operand lookup), the CDB (result write-back) and the commit consumers: RegFile, DataCache, PC and Branch_Predictor. Relative to the earlier fixed 8-entry ROB it adds:
- configurable depth;
- multiple CDB write ports;
- a ready/valid store handshake;
- registered commit pulses;
- explicit single-cycle flush on branch mispredict.

## Interface
Parameters:
- DEPTH, 8: entry count; power of two, at least 2. PTR_W = clog2(DEPTH).
- DATA_W, 32: value width. ADDR_W, 32: store address width and npc width.
- REG_W, 5: architectural register name width. BRA_W, 8: branch-predictor index width.
- CDB_PORTS, 2: number of CDB write ports.

Ports (name, direction, width, meaning):
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-low.
- alloc_valid  in  1  decoder requests one entry.
- alloc_ready  out  1  entry available; equals (count != DEPTH).
- alloc_op  in  3  operation code: 1=Branch, 2=Normal, 3=SB, 4=SH, 5=SW.
- alloc_reg  in  REG_W  destination register.
- alloc_bra_addr  in  BRA_W  predictor index.
- alloc_tag  out  PTR_W  tag of the entry the next allocation receives (the tail pointer).
- count  out  PTR_W+1  number of occupied entries.
- cdb_valid  in  CDB_PORTS  one write-back strobe per port.
- cdb_tag  in  CDB_PORTS*PTR_W  per-port entry tag.
- cdb_value  in  CDB_PORTS*DATA_W  result value, or store data.
- cdb_addr  in  CDB_PORTS*ADDR_W  store address; branch target for branches.
- cdb_mispredict  in  CDB_PORTS  branch resolved against its prediction.
- cdb_taken  in  CDB_PORTS  actual branch direction.
- chk_tag1, chk_tag2  in  PTR_W  operand lookup tags.
- chk_value1, chk_value2  out  DATA_W  stored value of the looked-up entry.
- chk_ready1, chk_ready2  out  1  looked-up entry is busy and ready.
- reg_modify  out  1  commit pulse to RegFile. reg_name  out  REG_W. reg_data  out  DATA_W. reg_entry  out  PTR_W.
- dcache_write  out  1  store pulse. dcache_mask  out  4. dcache_addr  out  ADDR_W (word-aligned). dcache_data  out  DATA_W.
- dcache_ready  in  1  DataCache can accept a store this cycle.
- pc_modify  out  1  redirect pulse. npc  out  ADDR_W  redirect target.
- brp_update  out  1  predictor update pulse. brp_addr  out  BRA_W. brp_result  out  1  actual direction.

## Operation
- Each entry holds: busy, ready, op, reg, value, addr, bra_addr, mispredict, taken.
- Allocation (alloc_valid && alloc_ready):
  - writes the entry at tail with busy=1, ready=0;
  - tail advances, wrapping mod DEPTH; count increments.
- CDB write: when cdb_valid[i], the entry at cdb_tag[i] takes value, addr, mispredict and taken, and sets ready=1.
  - Ignored if the entry is not busy, or is already ready.
  - If two ports hit the same tag in one cycle, the lowest-numbered port wins.
- Commit: only when the head entry is busy and ready. At most one commit per cycle. The head is cleared, head advances and count decrements.
  - Normal: reg_modify=1 with name, data, and reg_entry = head.
  - Branch: brp_update=1 with brp_addr and brp_result=taken.
    - If mispredict: also pc_modify=1, npc=addr, then flush.
  - Store: commits only when dcache_ready=1; otherwise the head stalls.
    - SB: mask = 1<<addr[1:0]; data = value<<(8*addr[1:0]).
    - SH: mask = addr[1] ? 4'b1100 : 4'b0011; data shifted by 16 when addr[1]=1.
    - SW: mask = 4'b1111.
    - dcache_addr = addr with bits [1:0] cleared.
    - Misaligned SH (addr[0]=1) or SW (addr[1:0]!=0): the entry retires with dcache_write=0.
- Flush: every entry's busy is cleared; head=tail=0 and count=0 at the next edge.
  - A same-cycle allocation is dropped.
  - Same-cycle CDB writes are dropped.
- Check ports are combinational reads. An index with busy=0 returns chk_ready=0 and chk_value=0.

## Timing
- Reset (rst=0, asynchronous):
  - head=tail=count=0; all busy=0;
  - every commit output is 0; alloc_ready=1; alloc_tag=0.
- Commit outputs are registered single-cycle pulses, asserted the cycle after the edge at which the head retires. Their data fields hold until the next pulse.
- CDB-to-commit latency: a value written at edge N can commit at edge N+1; the pulse is visible after N+1.
- Allocation and commit in the same cycle: count is unchanged.
- Allocation at count=DEPTH is ignored.
- An allocation into the slot being committed in the same cycle is legal; the new data wins.
- Pointer wrap from DEPTH-1 to 0 is seamless.
- Reset asserted mid-store: the dcache_write pulse is cleared immediately.

## Configuration
- ROB_CDB_BYPASS_EN defined: check ports also compare against the current-cycle CDB ports.
  - On a tag match to a busy entry: chk_ready=1 and chk_value = the CDB value of the lowest-numbered matching port.
- ROB_CDB_BYPASS_EN undefined: check ports see only stored state, so a CDB result becomes visible one cycle later.

## Test plan
- Reset, allocate 8 Normal entries (DEPTH=8) → alloc_ready=0 at count=8; a ninth alloc_valid is ignored and tail stays 0.
- CDB writes tags 2, 1, 0 (value 0x11 on tag 0) → nothing commits until tag 0 is ready; then reg_modify pulses for 0, 1, 2 in consecutive cycles and reg_data=0x11 first.
- SB with addr=0x1003, value=0xAB, dcache_ready held 0 for 3 cycles → head stalls; after release a single pulse with mask=4'b1000, data=0xAB000000, addr=0x1000.
- Branch with mispredict=1, addr=0x40, two younger entries → pc_modify=1, npc=0x40, brp_update=1; next cycle count=0, and a younger entry's CDB write is ignored.
- Both CDB ports write tag 3 in the same cycle (0x5, 0x9) → stored value 0x5; with ROB_CDB_BYPASS_EN, chk_tag1=3 returns 0x5 and ready=1 in that same cycle.
- Assert rst mid-run with count=5 → count=0, alloc_ready=1, all pulses 0 without waiting for a clock edge.
